// File: rtl/hacd_cmpct_sched.sv
// -----------------------------------------------------------------------------
// hacd_cmpct_sched
//
// Decides when the HACD datapath runs a compression or a compaction pass.
// Live free-page and fragmentation counts are compared against the programmed
// thresholds. One operation at a time is issued over a req/ack handshake.
// Each request is bounded by a timeout, and every operation is followed by a
// fixed hold-off gap.
//
// Parameters
//   TIMEOUT      cycles a request may stay outstanding before it is abandoned
//   HOLDOFF      idle cycles enforced after every operation (must be >= 1)
//
// Ports
//   clk_i        block clock
//   rst_ni       asynchronous active-low reset
//   ctrl_i       [0] scheduler enable, [1] compaction enable, others ignored
//   low_wm_i     low watermark in free pages
//   cmpct_th_i   fragmented-page count that triggers compaction
//   free_pages_i current free-page count
//   frag_cnt_i   current count of partially filled compressed pages
//   cmpr_req_o   compression request      / cmpr_ack_i   compression done
//   cmpct_req_o  compaction request       / cmpct_ack_i  compaction done
//   busy_o       high in every state except IDLE
//   timeout_o    sticky flag: a request timed out
//   op_cnt_o     saturating count of acknowledged operations
// -----------------------------------------------------------------------------
module hacd_cmpct_sched #(
    parameter int TIMEOUT = 1024,
    parameter int HOLDOFF = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] ctrl_i,
    input  logic [31:0] low_wm_i,
    input  logic [31:0] cmpct_th_i,
    input  logic [31:0] free_pages_i,
    input  logic [31:0] frag_cnt_i,
    output logic        cmpr_req_o,
    input  logic        cmpr_ack_i,
    output logic        cmpct_req_o,
    input  logic        cmpct_ack_i,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [15:0] op_cnt_o
);

    // One counter serves both the request wait and the hold-off gap.
    localparam int CNT_MAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HO_LAST  = CW'(HOLDOFF - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMPR  = 2'd1,
        ST_CMPCT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Saturating 16-bit increment for the operation counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            sat_inc16 = 16'hFFFF;
        end else begin
            sat_inc16 = val + 16'd1;
        end
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          timeout_r, timeout_s;
    logic [15:0]   op_cnt_r, op_cnt_s;
    logic          cmpr_req_r, cmpct_req_r, busy_r;

    logic          en_s;
    logic          trig_cmpr_s;
    logic          trig_cmpct_s;
    logic          unused_ctrl_s;

    assign en_s          = ctrl_i[0];
    assign trig_cmpr_s   = (free_pages_i < low_wm_i);
    assign trig_cmpct_s  = ctrl_i[1] && (frag_cnt_i >= cmpct_th_i);
    assign unused_ctrl_s = ^ctrl_i[31:2];

    // Next-state, counter, sticky-flag and op-count computation.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        timeout_s = timeout_r;
        op_cnt_s  = op_cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (!en_s) begin
                    timeout_s = 1'b0;
                end else if (trig_cmpr_s) begin
                    state_s = ST_CMPR;
                end else if (trig_cmpct_s) begin
                    state_s = ST_CMPCT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMPR, ST_CMPCT: begin
                // Only the ack matching the outstanding request counts; an ack
                // on the final wait cycle still beats the timeout.
                if ((state_r == ST_CMPR) ? cmpr_ack_i : cmpct_ack_i) begin
                    state_s  = ST_HOLD;
                    cnt_s    = CNT_ZERO;
                    op_cnt_s = sat_inc16(op_cnt_r);
                end else if (cnt_r == TO_LAST) begin
                    state_s   = ST_HOLD;
                    cnt_s     = CNT_ZERO;
                    timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_HOLD: begin
                // Disabling the scheduler clears the flag but never shortens HOLD.
                if (!en_s) begin
                    timeout_s = 1'b0;
                end else begin
                    timeout_s = timeout_r;
                end
                if (cnt_r == HO_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs (outputs decoded from next state).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            timeout_r   <= 1'b0;
            op_cnt_r    <= 16'h0000;
            cmpr_req_r  <= 1'b0;
            cmpct_req_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            timeout_r   <= timeout_s;
            op_cnt_r    <= op_cnt_s;
            cmpr_req_r  <= (state_s == ST_CMPR);
            cmpct_req_r <= (state_s == ST_CMPCT);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign cmpr_req_o  = cmpr_req_r;
    assign cmpct_req_o = cmpct_req_r;
    assign busy_o      = busy_r;
    assign timeout_o   = timeout_r;
    assign op_cnt_o    = op_cnt_r;

endmodule

// File: tb/tb_hacd_cmpct_sched.sv
module tb_hacd_cmpct_sched;

    logic        clk;
    logic        rst_n;
    logic [31:0] ctrl;
    logic [31:0] low_wm;
    logic [31:0] cmpct_th;
    logic [31:0] free_pages;
    logic [31:0] frag_cnt;
    logic        cmpr_req;
    logic        cmpr_ack;
    logic        cmpct_req;
    logic        cmpct_ack;
    logic        busy;
    logic        timeout;
    logic [15:0] op_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hacd_cmpct_sched #(.TIMEOUT(8), .HOLDOFF(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ctrl_i       (ctrl),
        .low_wm_i     (low_wm),
        .cmpct_th_i   (cmpct_th),
        .free_pages_i (free_pages),
        .frag_cnt_i   (frag_cnt),
        .cmpr_req_o   (cmpr_req),
        .cmpr_ack_i   (cmpr_ack),
        .cmpct_req_o  (cmpct_req),
        .cmpct_ack_i  (cmpct_ack),
        .busy_o       (busy),
        .timeout_o    (timeout),
        .op_cnt_o     (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) until busy drops; an expired bound is a failed check.
    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_wait_idle: busy=%b still high, required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ctrl = 32'd0; low_wm = 32'd0; cmpct_th = 32'hFFFF_FFFF;
        free_pages = 32'd0; frag_cnt = 32'd0; cmpr_ack = 1'b0; cmpct_ack = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmpr_req, cmpct_req, busy, timeout, op_cnt} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b_%b_%b_%b_%h required all 0",
                     cmpr_req, cmpct_req, busy, timeout, op_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_disabled: busy=%b required 0", busy);
        end
    endtask

    task automatic test_compression();
        low_wm = 32'd100; free_pages = 32'd99; ctrl = 32'd1;
        @(negedge clk);
        n_checks++;
        if (cmpr_req !== 1'b1 || busy !== 1'b1 || cmpct_req !== 1'b0) begin
            n_fail++;
            $display("FAIL cmpr_rise: req=%b busy=%b cmpct=%b required 1 1 0", cmpr_req, busy, cmpct_req);
        end
        free_pages = 32'd100;
        repeat (4) @(negedge clk);
        cmpr_ack = 1'b1;
        @(negedge clk);
        cmpr_ack = 1'b0;
        n_checks++;
        if (cmpr_req !== 1'b0 || op_cnt !== 16'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cmpr_ack: req=%b op_cnt=%0d busy=%b required 0 1 1", cmpr_req, op_cnt, busy);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_busy[%0d]: busy=%b required 1", i, busy);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_end: busy=%b required 0", busy);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (cmpr_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL free_eq_wm_no_req: req=%b busy=%b required 0 0", cmpr_req, busy);
        end
    endtask

    task automatic test_priority();
        logic seen;
        free_pages = 32'd10; low_wm = 32'd20; frag_cnt = 32'd50; cmpct_th = 32'd40; ctrl = 32'd3;
        @(negedge clk);
        n_checks++;
        if (cmpr_req !== 1'b1 || cmpct_req !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_cmpr_first: cmpr=%b cmpct=%b required 1 0", cmpr_req, cmpct_req);
        end
        free_pages = 32'd30;
        cmpr_ack = 1'b1;
        @(negedge clk);
        cmpr_ack = 1'b0;
        // HOLD occupies this and 15 more cycles, one IDLE evaluation, then CMPCT.
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            n_checks++;
            if (cmpct_req !== (i == 17) || cmpr_req !== 1'b0) begin
                n_fail++;
                $display("FAIL prio_cmpct_next[%0d]: cmpct=%b cmpr=%b required %b 0",
                         i, cmpct_req, cmpr_req, (i == 17));
            end
        end
        cmpct_ack = 1'b1;
        ctrl = 32'd1;
        @(negedge clk);
        cmpct_ack = 1'b0;
        n_checks++;
        if (cmpct_req !== 1'b0 || op_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL cmpct_ack: req=%b op_cnt=%0d required 0 3", cmpct_req, op_cnt);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cmpct_req === 1'b1 || cmpr_req === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL cmpct_gated_by_ctrl1: request seen=%b required 0", seen);
        end
        ctrl = 32'd3; cmpct_th = 32'hFFFF_FFFF; frag_cnt = 32'hFFFF_FFFE;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cmpct_req === 1'b1 || cmpr_req === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL cmpct_th_max: request seen=%b required 0", seen);
        end
    endtask

    task automatic test_timeout();
        int hi;
        // Ack on the last allowed cycle beats the timeout.
        ctrl = 32'd1; low_wm = 32'd1; free_pages = 32'd0;
        @(negedge clk);
        free_pages = 32'd1000;
        repeat (7) @(negedge clk);
        n_checks++;
        if (cmpr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL to_req_still_high_c8: req=%b required 1", cmpr_req);
        end
        cmpr_ack = 1'b1;
        @(negedge clk);
        cmpr_ack = 1'b0;
        n_checks++;
        if (cmpr_req !== 1'b0 || timeout !== 1'b0 || op_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL ack_on_last: req=%b timeout=%b op_cnt=%0d required 0 0 4", cmpr_req, timeout, op_cnt);
        end
        wait_idle("ack_on_last");
        // No ack: request high for exactly TIMEOUT cycles.
        free_pages = 32'd0;
        @(negedge clk);
        free_pages = 32'd1000;
        hi = 0;
        while (cmpr_req === 1'b1 && hi < 30) begin
            hi++;
            @(negedge clk);
        end
        n_checks++;
        if (hi !== 8) begin
            n_fail++;
            $display("FAIL timeout_len: request high %0d cycles, required 8", hi);
        end
        n_checks++;
        if (timeout !== 1'b1 || op_cnt !== 16'd4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_flag: timeout=%b op_cnt=%0d busy=%b required 1 4 1", timeout, op_cnt, busy);
        end
        wait_idle("timeout");
        n_checks++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: timeout=%b required 1", timeout);
        end
    endtask

    task automatic test_enable_drop();
        logic seen;
        ctrl = 32'd3; frag_cnt = 32'd50; cmpct_th = 32'd50;
        @(negedge clk);
        n_checks++;
        if (cmpct_req !== 1'b1) begin
            n_fail++;
            $display("FAIL cmpct_eq_th: req=%b required 1", cmpct_req);
        end
        ctrl = 32'd2;
        cmpr_ack = 1'b1;
        repeat (3) @(negedge clk);
        cmpr_ack = 1'b0;
        n_checks++;
        if (cmpct_req !== 1'b1 || timeout !== 1'b1 || op_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL en_drop_hold_req: req=%b timeout=%b op_cnt=%0d required 1 1 4", cmpct_req, timeout, op_cnt);
        end
        cmpct_ack = 1'b1;
        @(negedge clk);
        cmpct_ack = 1'b0;
        n_checks++;
        if (cmpct_req !== 1'b0 || busy !== 1'b1 || op_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL en_drop_ack: req=%b busy=%b op_cnt=%0d required 0 1 5", cmpct_req, busy, op_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL en_drop_clear_in_hold: timeout=%b busy=%b required 0 1", timeout, busy);
        end
        wait_idle("en_drop");
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (cmpct_req === 1'b1 || cmpr_req === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_no_new_req: activity=%b required 0", seen);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_cnt [3];
        exp_cnt[0] = 16'hFFFE; exp_cnt[1] = 16'hFFFF; exp_cnt[2] = 16'hFFFF;
        ctrl = 32'd0;
        force dut.op_cnt_r = 16'hFFFD;
        repeat (2) @(negedge clk);
        release dut.op_cnt_r;
        @(negedge clk);
        n_checks++;
        if (op_cnt !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL sat_preload: op_cnt=%h required fffd", op_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            ctrl = 32'd1; low_wm = 32'd1; free_pages = 32'd0;
            @(negedge clk);
            free_pages = 32'd1000;
            cmpr_ack = 1'b1;
            @(negedge clk);
            cmpr_ack = 1'b0;
            n_checks++;
            if (op_cnt !== exp_cnt[i]) begin
                n_fail++;
                $display("FAIL sat_op_cnt[%0d]: op_cnt=%h required %h", i, op_cnt, exp_cnt[i]);
            end
            wait_idle("sat");
        end
    endtask

    task automatic test_reset_mid_request();
        ctrl = 32'd1; low_wm = 32'd1; free_pages = 32'd0;
        @(negedge clk);
        n_checks++;
        if (cmpr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_req: req=%b required 1", cmpr_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cmpr_req, cmpct_req, busy, timeout, op_cnt} !== 20'd0) begin
            n_fail++;
            $display("FAIL rst_mid_req: got %b_%b_%b_%b_%h required all 0",
                     cmpr_req, cmpct_req, busy, timeout, op_cnt);
        end
        ctrl = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_compression();
        test_priority();
        test_timeout();
        test_enable_drop();
        test_saturation();
        test_reset_mid_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
